// File: rtl/booth_mul_sched.sv
// booth_mul_sched
//   Round-robin front end for a single shared sequential Booth multiplier
//   core. One transaction is in flight at a time:
//   IDLE (grant/accept) -> ISSUE (start pulse) -> WAIT (core busy,
//   watchdog running) -> RESP (hold result until accepted).
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid/req_ready    per-requester handshake (NREQ bits)
//   req_mc/req_mp          packed operands, slice i belongs to requester i
//   mul_start/mul_abort    one-cycle control pulses to the core
//   mul_mc/mul_mp          operands to the core, stable ISSUE..WAIT
//   mul_done/mul_prod      core completion and product
//   rsp_valid/rsp_ready    response handshake
//   rsp_prod/rsp_id/rsp_err signed product, requester index, timeout flag
//
// Build option
//   BOOTH_SCHED_ZERO_BYPASS_EN : a zero operand skips the core and answers
//   with product 0 on the cycle after accept.
module booth_mul_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WIDTH-1:0]      req_mc,
  input  logic [NREQ*WIDTH-1:0]      req_mp,
  output logic                       mul_start,
  output logic                       mul_abort,
  output logic [WIDTH-1:0]           mul_mc,
  output logic [WIDTH-1:0]           mul_mp,
  input  logic                       mul_done,
  input  logic [2*WIDTH-1:0]         mul_prod,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*WIDTH-1:0]         rsp_prod,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic                       rsp_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   mc_q, mc_d, mp_q, mp_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;

  logic               gnt_vld;
  logic [IDW-1:0]     gnt_idx;
  logic               accept;
  logic               tmo_hit;
  logic [WIDTH-1:0]   sel_mc, sel_mp;
  int                 j;

  // First valid requester at or after ptr, wrapping. Scanning from the far
  // end down lets the closest candidate overwrite the others.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (req_valid[j]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

  assign accept  = (state_q == S_IDLE) && gnt_vld;
  assign sel_mc  = req_mc[gnt_idx*WIDTH +: WIDTH];
  assign sel_mp  = req_mp[gnt_idx*WIDTH +: WIDTH];
  // Last WAIT cycle of the watchdog window; a done in this cycle still wins.
  assign tmo_hit = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mc_d    = sel_mc;
          mp_d    = sel_mp;
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = S_ISSUE;
`ifdef BOOTH_SCHED_ZERO_BYPASS_EN
          if ((sel_mc == '0) || (sel_mp == '0)) begin
            prod_d  = '0;
            err_d   = 1'b0;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_done) begin
          prod_d  = mul_prod;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmo_hit) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      default: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  // Combinational pulses are gated by rst_n so a reset landing mid-WAIT
  // can never leak a start/abort to the core.
  assign req_ready = (rst_n && accept) ? (NREQ'(1) << gnt_idx) : '0;
  assign mul_start = rst_n && (state_q == S_ISSUE);
  assign mul_abort = rst_n && tmo_hit && !mul_done;
  assign mul_mc    = mc_q;
  assign mul_mp    = mp_q;
  assign rsp_valid = rst_n && (state_q == S_RESP);
  assign rsp_prod  = prod_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule
